porta_giratoria_arbitro: RTL and testbench



---
 rtl/porta_giratoria_arbitro_if.sv | 37 +++
 rtl/porta_giratoria_arbitro.sv | 134 +++++++++++++
 tb/tb_porta_giratoria_arbitro.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/porta_giratoria_arbitro_if.sv
// Revolving-door controller bundle: push-button/sensor inputs and LED/lock outputs.
// CONTADOR_PESSOAS_EN adds the occupancy count to the bundle.
interface porta_giratoria_arbitro_if #(
   parameter int LOTACAO_MAX = 15
);
   localparam int CNT_W = $clog2(LOTACAO_MAX + 1);

   logic       req_entrada;
   logic       req_saida;
   logic       sensor_passagem;
   logic       detector_metal;
   logic       liberar_guarda;
   logic [1:0] ledVerde;
   logic [1:0] ledVermelho;
   logic       trava;
   logic       ocupado;
   logic       alarme;
`ifdef CONTADOR_PESSOAS_EN
   logic [CNT_W-1:0] contagem;
`endif

   modport slave (
`ifdef CONTADOR_PESSOAS_EN
      output contagem,
`endif
      input  req_entrada, req_saida, sensor_passagem, detector_metal, liberar_guarda,
      output ledVerde, ledVermelho, trava, ocupado, alarme
   );

   modport master (
`ifdef CONTADOR_PESSOAS_EN
      input  contagem,
`endif
      output req_entrada, req_saida, sensor_passagem, detector_metal, liberar_guarda,
      input  ledVerde, ledVermelho, trava, ocupado, alarme
   );
endinterface

// File: rtl/porta_giratoria_arbitro.sv
// Round-robin arbiter for one revolving door shared by entry and exit, with passage
// timeout, guard interval and metal-detector lockout. CONTADOR_PESSOAS_EN adds occupancy gating.
module porta_giratoria_arbitro #(
   parameter int TEMPO_PASSAGEM  = 8,
   parameter int TEMPO_INTERVALO = 2,
   parameter int CONT_W          = 4,
   parameter int LOTACAO_MAX     = 15
) (
   input  logic                          clock,
   input  logic                          reset,
   porta_giratoria_arbitro_if.slave      bus
);
   typedef enum logic [2:0] {
      OCIOSO, LIBERA_ENTRADA, LIBERA_SAIDA, INTERVALO, BLOQUEADO
   } estado_t;

   localparam logic [CONT_W-1:0] FIM_PASSAGEM  = CONT_W'(TEMPO_PASSAGEM - 1);
   localparam logic [CONT_W-1:0] FIM_INTERVALO = CONT_W'(TEMPO_INTERVALO - 1);

   estado_t           estado_q, estado_d;
   logic [CONT_W-1:0] timer_q, timer_d;
   logic              ultimo_entrada_q, ultimo_entrada_d;
   logic              req_entrada_ok;

`ifdef CONTADOR_PESSOAS_EN
   localparam int CNT_W = $clog2(LOTACAO_MAX + 1);
   localparam logic [CNT_W-1:0] LOTADO = CNT_W'(LOTACAO_MAX);

   logic [CNT_W-1:0] contagem_q, contagem_d;

   // A full room only blocks new entries; exits still drain it.
   assign req_entrada_ok = bus.req_entrada && (contagem_q != LOTADO);
   assign bus.contagem   = contagem_q;

   always_comb begin
      contagem_d = contagem_q;
      if (estado_q == LIBERA_ENTRADA && bus.sensor_passagem && !bus.detector_metal &&
          contagem_q != LOTADO)
         contagem_d = contagem_q + 1'b1;
      else if (estado_q == LIBERA_SAIDA && bus.sensor_passagem && contagem_q != '0)
         contagem_d = contagem_q - 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) contagem_q <= '0;
      else       contagem_q <= contagem_d;
   end
`else
   assign req_entrada_ok = bus.req_entrada;
`endif

   always_comb begin
      estado_d         = estado_q;
      timer_d          = timer_q + 1'b1;
      ultimo_entrada_d = ultimo_entrada_q;
      case (estado_q)
         OCIOSO: begin
            timer_d = '0;
            // On a tie the side that was not served last wins.
            if (req_entrada_ok && (!bus.req_saida || !ultimo_entrada_q)) begin
               estado_d         = LIBERA_ENTRADA;
               ultimo_entrada_d = 1'b1;
            end else if (bus.req_saida) begin
               estado_d         = LIBERA_SAIDA;
               ultimo_entrada_d = 1'b0;
            end
         end
         LIBERA_ENTRADA: begin
            if (bus.detector_metal) begin
               estado_d = BLOQUEADO;
               timer_d  = '0;
            end else if (bus.sensor_passagem || timer_q == FIM_PASSAGEM) begin
               estado_d = INTERVALO;
               timer_d  = '0;
            end
         end
         LIBERA_SAIDA: begin
            if (bus.sensor_passagem || timer_q == FIM_PASSAGEM) begin
               estado_d = INTERVALO;
               timer_d  = '0;
            end
         end
         INTERVALO: begin
            if (timer_q == FIM_INTERVALO) begin
               estado_d = OCIOSO;
               timer_d  = '0;
            end
         end
         BLOQUEADO: begin
            timer_d = '0;
            if (bus.liberar_guarda) estado_d = INTERVALO;
         end
         default: begin
            estado_d = OCIOSO;
            timer_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q         <= OCIOSO;
         timer_q          <= '0;
         ultimo_entrada_q <= 1'b0;
      end else begin
         estado_q         <= estado_d;
         timer_q          <= timer_d;
         ultimo_entrada_q <= ultimo_entrada_d;
      end
   end

   always_comb begin
      bus.ledVerde    = 2'b00;
      bus.ledVermelho = 2'b11;
      bus.trava       = 1'b1;
      bus.ocupado     = 1'b1;
      bus.alarme      = 1'b0;
      case (estado_q)
         OCIOSO:         bus.ocupado = 1'b0;
         LIBERA_ENTRADA: begin
            bus.ledVerde    = 2'b10;
            bus.ledVermelho = 2'b01;
            bus.trava       = 1'b0;
         end
         LIBERA_SAIDA: begin
            bus.ledVerde    = 2'b01;
            bus.ledVermelho = 2'b10;
            bus.trava       = 1'b0;
         end
         BLOQUEADO:      bus.alarme = 1'b1;
         default:        ;
      endcase
   end
endmodule

// File: tb/tb_porta_giratoria_arbitro.sv
// Bench for porta_giratoria_arbitro: vector table through a scoreboard queue,
// plus hand-written reset-mid-grant and occupancy (CONTADOR_PESSOAS_EN) sequences.
module tb_porta_giratoria_arbitro;
   localparam int LOT = 2;

   typedef enum int {E_OC, E_LE, E_LS, E_INT, E_BL} est_t;
   typedef struct {
      logic rst, re, rs, sp, dm, lg;
      est_t exp;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   vec_t tab[$];
   est_t sb[$];

   porta_giratoria_arbitro_if #(.LOTACAO_MAX(LOT)) bus ();

   porta_giratoria_arbitro #(
      .TEMPO_PASSAGEM(8), .TEMPO_INTERVALO(2), .CONT_W(4), .LOTACAO_MAX(LOT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   // {verde, vermelho, trava, ocupado, alarme}
   function automatic logic [6:0] esperado(est_t e);
      case (e)
         E_OC:    return 7'b00_11_1_0_0;
         E_LE:    return 7'b10_01_0_1_0;
         E_LS:    return 7'b01_10_0_1_0;
         E_INT:   return 7'b00_11_1_1_0;
         default: return 7'b00_11_1_1_1;
      endcase
   endfunction

   function automatic void add(logic rst, logic re, logic rs, logic sp, logic dm, logic lg, est_t e);
      vec_t v;
      v.rst = rst; v.re = re; v.rs = rs; v.sp = sp; v.dm = dm; v.lg = lg; v.exp = e;
      tab.push_back(v);
   endfunction

   task automatic check(est_t e, string tag);
      logic [6:0] got, want;
      got  = {bus.ledVerde, bus.ledVermelho, bus.trava, bus.ocupado, bus.alarme};
      want = esperado(e);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got verde/verm/trava/ocup/alarme=%b want %b", tag, got, want);
      end
   endtask

`ifdef CONTADOR_PESSOAS_EN
   task automatic check_cnt(int want, string tag);
      total++;
      if (int'(bus.contagem) != want) begin
         bad++;
         $display("FAIL %s: contagem got %0d want %0d", tag, bus.contagem, want);
      end
   endtask
`endif

   task automatic apply(logic rst, logic re, logic rs, logic sp, logic dm, logic lg,
                        est_t e, string tag);
      est_t x;
      @(negedge clock);
      reset               = rst;
      bus.req_entrada     = re;
      bus.req_saida       = rs;
      bus.sensor_passagem = sp;
      bus.detector_metal  = dm;
      bus.liberar_guarda  = lg;
      sb.push_back(e);
      @(posedge clock);
      #1;
      x = sb.pop_front();
      check(x, tag);
   endtask

   initial begin
      reset               = 1'b1;
      bus.req_entrada     = 1'b0;
      bus.req_saida       = 1'b0;
      bus.sensor_passagem = 1'b0;
      bus.detector_metal  = 1'b0;
      bus.liberar_guarda  = 1'b0;
      #1;
      check(E_OC, "reset");
`ifdef CONTADOR_PESSOAS_EN
      check_cnt(0, "reset_cnt");
`endif

      // idle after reset, stray guard/sensor ignored
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, E_OC);
      add(0, 0, 0, 0, 0, 1, E_OC);
      add(0, 0, 0, 1, 0, 0, E_OC);
      // single entry, passage three cycles after the grant
      add(0, 1, 0, 0, 0, 0, E_LE);
      add(0, 0, 0, 0, 0, 0, E_LE);
      add(0, 0, 0, 0, 0, 0, E_LE);
      add(0, 0, 0, 1, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_OC);
      // both held from reset: entrada, saida, entrada with timeouts
      add(1, 0, 0, 0, 0, 0, E_OC);
      for (int g = 0; g < 3; g++) begin
         for (int c = 0; c < 8; c++) add(0, 1, 1, 0, 0, 0, (g == 1) ? E_LS : E_LE);
         add(0, 1, 1, 0, 0, 0, E_INT);
         add(0, 1, 1, 0, 0, 0, E_INT);
         add(0, 1, 1, 0, 0, 0, E_OC);
      end
      add(0, 0, 0, 0, 0, 0, E_OC);
      // metal hit beats passage on entry; lockout until guard releases
      add(0, 1, 0, 0, 0, 0, E_LE);
      add(0, 0, 0, 0, 0, 0, E_LE);
      add(0, 0, 0, 1, 1, 0, E_BL);
      for (int i = 0; i < 10; i++) add(0, 1, 1, i % 2, (i % 3) == 0, 0, E_BL);
      add(0, 0, 0, 0, 0, 1, E_INT);
      add(0, 0, 0, 0, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_OC);
      // metal ignored on exit; sensor ignored during the interval
      add(0, 0, 1, 0, 0, 0, E_LS);
      add(0, 0, 0, 0, 1, 0, E_LS);
      add(0, 0, 0, 0, 1, 0, E_LS);
      add(0, 0, 0, 1, 1, 0, E_INT);
      add(0, 0, 0, 1, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_OC);
      // tie after an exit goes to entrada
      add(0, 1, 1, 0, 0, 0, E_LE);
      add(0, 0, 0, 1, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_INT);
      add(0, 0, 0, 0, 0, 0, E_OC);

      for (int i = 0; i < tab.size(); i++)
         apply(tab[i].rst, tab[i].re, tab[i].rs, tab[i].sp, tab[i].dm, tab[i].lg,
               tab[i].exp, $sformatf("vec%0d", i));

      // reset mid-grant relocks immediately and restores the tie pointer
      apply(0, 1, 0, 0, 0, 0, E_LE, "mid_grant");
      apply(0, 0, 0, 0, 0, 0, E_LE, "mid_hold");
      @(negedge clock);
      reset = 1'b1;
      #1;
      check(E_OC, "rst_async");
      @(posedge clock);
      #1;
      check(E_OC, "rst_held");
      apply(0, 1, 1, 0, 0, 0, E_LE, "tie_after_rst");
      apply(0, 0, 0, 1, 0, 0, E_INT, "tie_pass");
      apply(0, 0, 0, 0, 0, 0, E_INT, "tie_int");
      apply(0, 0, 0, 0, 0, 0, E_OC, "tie_idle");

`ifdef CONTADOR_PESSOAS_EN
      apply(1, 0, 0, 0, 0, 0, E_OC, "cnt_rst");
      check_cnt(0, "cnt_zero");
      for (int k = 0; k < 2; k++) begin
         apply(0, 1, 0, 0, 0, 0, E_LE, "cnt_in_grant");
         apply(0, 0, 0, 1, 0, 0, E_INT, "cnt_in_pass");
         check_cnt(k + 1, "cnt_in");
         apply(0, 0, 0, 0, 0, 0, E_INT, "cnt_in_int");
         apply(0, 0, 0, 0, 0, 0, E_OC, "cnt_in_idle");
      end
      apply(0, 1, 0, 0, 0, 0, E_OC, "cnt_full_block0");
      apply(0, 1, 0, 0, 0, 0, E_OC, "cnt_full_block1");
      check_cnt(2, "cnt_full");
      apply(0, 1, 1, 0, 0, 0, E_LS, "cnt_exit_grant");
      apply(0, 0, 0, 1, 0, 0, E_INT, "cnt_exit_pass");
      check_cnt(1, "cnt_exit");
      apply(0, 0, 0, 0, 0, 0, E_INT, "cnt_exit_int");
      apply(0, 0, 0, 0, 0, 0, E_OC, "cnt_exit_idle");
      apply(0, 1, 0, 0, 0, 0, E_LE, "cnt_reentry");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
